// File: rtl/wb_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_write_queue: dual-producer register write-back queue with forwarding.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_W-1:0]          a_reg,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_W-1:0]          b_reg,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       wb_we,
  output logic [ADDR_W-1:0]          wb_reg,
  output logic [DATA_W-1:0]          wb_data,
  input  logic [ADDR_W-1:0]          rd1_reg,
  output logic                       rd1_hit,
  output logic [DATA_W-1:0]          rd1_data,
  input  logic [ADDR_W-1:0]          rd2_reg,
  output logic                       rd2_hit,
  output logic [DATA_W-1:0]          rd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]  free_w;
  logic              a_claims_w;
  logic              push_a_w, push_b_w, pop_w;
  logic [PTR_W-1:0]  tail_b_w;

  assign free_w     = CNT_W'(DEPTH) - count_q;
  // A request to $0 never occupies a slot, so it must not steal B's space.
  assign a_claims_w = a_valid & (a_reg != '0);

  assign a_ready  = (free_w != '0);
  assign b_ready  = (free_w >= CNT_W'(2)) | ((free_w != '0) & ~a_claims_w);

  assign push_a_w = a_valid & a_ready & (a_reg != '0);
  assign push_b_w = b_valid & b_ready & (b_reg != '0);
  assign pop_w    = (count_q != '0);
  assign tail_b_w = tail_q + PTR_W'(push_a_w);

  assign head_d  = head_q + PTR_W'(pop_w);
  assign tail_d  = tail_q + PTR_W'(push_a_w) + PTR_W'(push_b_w);
  assign count_d = count_q + CNT_W'(push_a_w) + CNT_W'(push_b_w) - CNT_W'(pop_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_a_w) begin
      reg_q[tail_q]  <= a_reg;
      data_q[tail_q] <= a_data;
    end
    if (push_b_w) begin
      reg_q[tail_b_w]  <= b_reg;
      data_q[tail_b_w] <= b_data;
    end
  end

  // Walk oldest to newest so the latest matching entry overrides earlier ones.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (reg_q[idx] == r) && (r != '0))
        res = {1'b1, data_q[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {rd1_hit, rd1_data} = lookup(rd1_reg);
    {rd2_hit, rd2_data} = lookup(rd2_reg);
  end

  assign wb_we   = pop_w;
  assign wb_reg  = pop_w ? reg_q[head_q]  : '0;
  assign wb_data = pop_w ? data_q[head_q] : '0;
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_write_queue: scoreboard bench for the write-back queue.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [ADDR_W-1:0] a_reg, b_reg, wb_reg, rd1_reg, rd2_reg;
  logic [DATA_W-1:0] a_data, b_data, wb_data, rd1_data, rd2_data;
  logic              wb_we, rd1_hit, rd2_hit, full, empty;
  logic [CNT_W-1:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .rd1_reg(rd1_reg), .rd1_hit(rd1_hit), .rd1_data(rd1_data),
    .rd2_reg(rd2_reg), .rd2_hit(rd2_hit), .rd2_data(rd2_data),
    .count(count), .full(full), .empty(empty)
  );

  // Drives one cycle from a negedge, checks DUT against the queue model, then
  // advances the model on the rising edge (drain first, then A, then B).
  task automatic cycle(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                       output logic acc_a, output logic acc_b);
    int cnt, free;
    logic exp_ar, exp_br, h1, h2;
    logic [DATA_W-1:0] d1, d2, exp_wd;
    logic [ADDR_W-1:0] exp_wr;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    rd1_reg = r1; rd2_reg = r2;
    #1;
    cnt = sb.size(); free = DEPTH - cnt;
    exp_ar = (free >= 1);
    exp_br = (free >= 2) || ((free >= 1) && !(av && ar != '0));
    exp_wr = (cnt != 0) ? sb[0][ADDR_W+DATA_W-1:DATA_W] : '0;
    exp_wd = (cnt != 0) ? sb[0][DATA_W-1:0] : '0;
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    for (int i = 0; i < cnt; i++) begin
      if (r1 != '0 && sb[i][ADDR_W+DATA_W-1:DATA_W] == r1) begin h1 = 1'b1; d1 = sb[i][DATA_W-1:0]; end
      if (r2 != '0 && sb[i][ADDR_W+DATA_W-1:DATA_W] == r2) begin h2 = 1'b1; d2 = sb[i][DATA_W-1:0]; end
    end
    checks++; if (a_ready !== exp_ar) begin failures++; $display("FAIL a_ready got=%0b exp=%0b t=%0t", a_ready, exp_ar, $time); end
    checks++; if (b_ready !== exp_br) begin failures++; $display("FAIL b_ready got=%0b exp=%0b t=%0t", b_ready, exp_br, $time); end
    checks++; if (count !== CNT_W'(cnt)) begin failures++; $display("FAIL count got=%0d exp=%0d t=%0t", count, cnt, $time); end
    checks++; if (wb_we !== (cnt != 0)) begin failures++; $display("FAIL wb_we got=%0b exp=%0b t=%0t", wb_we, cnt != 0, $time); end
    checks++; if (wb_reg !== exp_wr || wb_data !== exp_wd) begin failures++; $display("FAIL wb_entry got=%0d/%0h exp=%0d/%0h t=%0t", wb_reg, wb_data, exp_wr, exp_wd, $time); end
    checks++; if (rd1_hit !== h1 || rd1_data !== d1) begin failures++; $display("FAIL rd1 got=%0b/%0h exp=%0b/%0h t=%0t", rd1_hit, rd1_data, h1, d1, $time); end
    checks++; if (rd2_hit !== h2 || rd2_data !== d2) begin failures++; $display("FAIL rd2 got=%0b/%0h exp=%0b/%0h t=%0t", rd2_hit, rd2_data, h2, d2, $time); end
    checks++; if (full !== (cnt == DEPTH) || empty !== (cnt == 0)) begin failures++; $display("FAIL flags got=%0b%0b exp=%0b%0b t=%0t", full, empty, cnt == DEPTH, cnt == 0, $time); end
    acc_a = av && exp_ar;
    acc_b = bv && exp_br;
    @(posedge clk);
    if (cnt != 0) void'(sb.pop_front());
    if (acc_a && ar != '0) sb.push_back({ar, ad});
    if (acc_b && br != '0) sb.push_back({br, bd});
    @(negedge clk);
  endtask

  task automatic idle(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    logic xa, xb;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2, xa, xb);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    rd1_reg = 5'd1; rd2_reg = 5'd2;
    #3;
    checks++; if (wb_we !== 1'b0 || wb_reg !== '0 || wb_data !== '0) begin failures++; $display("FAIL reset_wb got=%0b/%0d/%0h exp=0/0/0", wb_we, wb_reg, wb_data); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== '0) begin failures++; $display("FAIL reset_flags got=e%0b f%0b c%0d exp=e1 f0 c0", empty, full, count); end
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b%0b exp=11", a_ready, b_ready); end
    checks++; if (rd1_hit !== 1'b0 || rd2_hit !== 1'b0 || rd1_data !== '0 || rd2_data !== '0) begin failures++; $display("FAIL reset_rd got=%0b%0b exp=00", rd1_hit, rd2_hit); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_write;
    logic xa, xb;
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, '0, xa, xb);
    a_valid = 1'b0; rd1_reg = 5'd5;
    #1;
    checks++; if (wb_we !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'h1234) begin failures++; $display("FAIL single_wb got=%0b/%0d/%0h exp=1/5/1234", wb_we, wb_reg, wb_data); end
    checks++; if (rd1_hit !== 1'b1 || rd1_data !== 32'h1234) begin failures++; $display("FAIL single_fwd got=%0b/%0h exp=1/1234", rd1_hit, rd1_data); end
    idle(5'd5, '0);
    #1;
    checks++; if (empty !== 1'b1 || wb_we !== 1'b0) begin failures++; $display("FAIL single_empty got=e%0b we%0b exp=e1 we0", empty, wb_we); end
  endtask

  task automatic test_dual_push;
    logic xa, xb;
    cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, '0, xa, xb);
    a_valid = 1'b0; b_valid = 1'b0; rd1_reg = 5'd3;
    #1;
    checks++; if (rd1_hit !== 1'b1 || rd1_data !== 32'hB) begin failures++; $display("FAIL dual_fwd got=%0b/%0h exp=1/b", rd1_hit, rd1_data); end
    checks++; if (count !== 3'd2 || wb_data !== 32'hA) begin failures++; $display("FAIL dual_first got=c%0d/%0h exp=c2/a", count, wb_data); end
    idle(5'd3, '0);
    #1;
    checks++; if (count !== 3'd1 || wb_data !== 32'hB) begin failures++; $display("FAIL dual_second got=c%0d/%0h exp=c1/b", count, wb_data); end
    idle(5'd3, '0);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL dual_drained got=%0d exp=0", count); end
  endtask

  task automatic test_backpressure;
    logic acc_a, acc_b;
    logic [ADDR_W-1:0] ar, br;
    logic [DATA_W-1:0] ad, bd;
    int k = 0;
    ar = 5'd1; ad = $urandom; br = 5'd16; bd = $urandom;
    for (int n = 0; n < 30; n++) begin
      cycle(1'b1, ar, ad, 1'b1, br, bd, ar, br, acc_a, acc_b);
      checks++; if (count > 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp<=4", count); end
      if (acc_a) begin k++; ar = ADDR_W'(1 + (k % 15)); ad = $urandom; end
      if (acc_b) begin k++; br = ADDR_W'(16 + (k % 15)); bd = $urandom; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int n = 0; n < 10 && sb.size() != 0; n++) idle(ar, br);
    #1;
    checks++; if (empty !== 1'b1 || sb.size() != 0) begin failures++; $display("FAIL bp_drain got=e%0b model=%0d exp=e1 model=0", empty, sb.size()); end
  endtask

  task automatic test_reg0;
    logic xa, xb;
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, '0, '0, xa, xb);
    checks++; if (xa !== 1'b1) begin failures++; $display("FAIL reg0_accept got=%0b exp=1", xa); end
    a_valid = 1'b0; #1;
    checks++; if (count !== 3'd0 || wb_we !== 1'b0) begin failures++; $display("FAIL reg0_store got=c%0d we%0b exp=c0 we0", count, wb_we); end
    cycle(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'h10, '0, '0, xa, xb);
    cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 5'd9, '0, xa, xb);
    // free == 1 here; an A request to $0 leaves that slot to B.
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd13, 32'h13, 5'd12, '0, xa, xb);
    checks++; if (xb !== 1'b1) begin failures++; $display("FAIL reg0_b_slot got=%0b exp=1", xb); end
    a_valid = 1'b0; b_valid = 1'b0; rd2_reg = '0; #1;
    checks++; if (count !== 3'd3 || rd2_hit !== 1'b0) begin failures++; $display("FAIL reg0_after got=c%0d h%0b exp=c3 h0", count, rd2_hit); end
    for (int n = 0; n < 8 && sb.size() != 0; n++) idle(5'd13, '0);
  endtask

  task automatic test_reset_mid;
    logic xa, xb;
    cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, '0, '0, xa, xb);
    cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, '0, '0, xa, xb);
    a_valid = 1'b0; b_valid = 1'b0; rd1_reg = 5'd23; rd2_reg = 5'd22;
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_setup got=%0d exp=3", count); end
    #1 rst = 1'b1;
    #1;
    checks++; if (wb_we !== 1'b0 || count !== '0 || empty !== 1'b1) begin failures++; $display("FAIL mid_reset got=we%0b c%0d exp=we0 c0", wb_we, count); end
    checks++; if (rd1_hit !== 1'b0 || rd2_hit !== 1'b0) begin failures++; $display("FAIL mid_reset_rd got=%0b%0b exp=00", rd1_hit, rd2_hit); end
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, '0, '0, xa, xb);
    a_valid = 1'b0; #1;
    checks++; if (wb_we !== 1'b1 || wb_reg !== 5'd7 || wb_data !== 32'h77) begin failures++; $display("FAIL mid_after got=%0b/%0d/%0h exp=1/7/77", wb_we, wb_reg, wb_data); end
    idle('0, '0);
    idle('0, '0);
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_dual_push;
    test_backpressure;
    test_reg0;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
